us_cmd_dispatch: RTL and testbench

US_CMD_DISPATCH -- requirements
Module: us_cmd_dispatch

---
 rtl/us_cmd_dispatch_if.sv | 25 ++
 rtl/us_cmd_dispatch.sv | 152 +++++++++++++++
 tb/tb_us_cmd_dispatch.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/us_cmd_dispatch_if.sv
// Upstream command dispatch bus: command FIFO read port plus the TX-engine request port.
// tx handshake: tx_req_o rises with type/addr/len/info stable and stays high; the
// request is accepted on the rising edge where tx_ack_i is high; tx_ack_i is
// ignored whenever tx_req_o is low. The FIFO has a 1-cycle read latency after rd_en.
interface us_cmd_dispatch_if;
  logic         us_cmd_fifo_empty_i;
  logic [127:0] us_cmd_fifo_dout_i;
  logic         us_cmd_fifo_rd_en_o;
  logic         tx_req_o;
  logic [1:0]   tx_type_o;
  logic [31:0]  tx_addr_o;
  logic [9:0]   tx_len_o;
  logic [54:0]  tx_cpl_info_o;
  logic         tx_ack_i;

  modport master (
    input  us_cmd_fifo_empty_i, us_cmd_fifo_dout_i, tx_ack_i,
    output us_cmd_fifo_rd_en_o, tx_req_o, tx_type_o, tx_addr_o, tx_len_o, tx_cpl_info_o
  );

  modport slave (
    output us_cmd_fifo_empty_i, us_cmd_fifo_dout_i, tx_ack_i,
    input  us_cmd_fifo_rd_en_o, tx_req_o, tx_type_o, tx_addr_o, tx_len_o, tx_cpl_info_o
  );
endinterface

// File: rtl/us_cmd_dispatch.sv
// Pops upstream commands and turns them into TX requests: completions pass through,
// memory writes are split on payload size and 4KB boundaries.
module us_cmd_dispatch #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 128,
  parameter logic [1:0]  CMD_INVALID       = 2'd0,
  parameter logic [1:0]  CMD_CPL           = 2'd1,
  parameter logic [1:0]  CMD_CPLD          = 2'd2,
  parameter logic [1:0]  CMD_WR32          = 2'd3
) (
  input  logic              clk,
  input  logic              rst_n,
  us_cmd_dispatch_if.master bus,
  output logic              up_wr_cmd_compl_o,
  output logic [1:0]        cmd_id_o,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_CPL_REQ = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_GAP  = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [127:0]  cmd_q;
  logic [31:0]   addr_q;
  logic [16:0]   rem_q;
  logic [7:0]    err_q;
  logic          pop_ok_q;

  logic [1:0]    dec_type;
  logic          dec_cpl;
  logic          dec_wr;
  logic          dec_bad;
  logic [4:0]    len_raw;
  logic [4:0]    len_clamp;
  logic [12:0]   to_boundary;
  logic [16:0]   max_pl;
  logic [16:0]   chunk;
  logic          last_chunk;
  logic          unused_hi;

  assign dec_type = cmd_q[63:62];
  assign dec_cpl  = (dec_type == CMD_CPL) || (dec_type == CMD_CPLD);
  assign dec_wr   = !dec_cpl && (dec_type == CMD_WR32);
  assign dec_bad  = (dec_type == CMD_INVALID) || (!dec_cpl && !dec_wr);
  assign len_raw  = cmd_q[61:57];
  assign unused_hi = ^cmd_q[127:64];

  always_comb begin
    len_clamp = len_raw;
    if (len_raw < 5'd2)       len_clamp = 5'd2;
    else if (len_raw > 5'd16) len_clamp = 5'd16;
  end

  // Chunk is the smallest of what is left, the payload cap and the room before the next 4KB line.
  assign to_boundary = 13'h1000 - {1'b0, addr_q[11:0]};
  assign max_pl      = 17'(MAX_PAYLOAD_BYTES);

  always_comb begin
    chunk = rem_q;
    if (max_pl < chunk)                chunk = max_pl;
    if ({4'd0, to_boundary} < chunk)   chunk = {4'd0, to_boundary};
  end

  assign last_chunk = (rem_q == chunk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    bus.us_cmd_fifo_rd_en_o = 1'b0;
    bus.tx_req_o            = 1'b0;
    up_wr_cmd_compl_o       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // pop_ok_q keeps the first pop off the edge on which reset is released
        if (pop_ok_q && !bus.us_cmd_fifo_empty_i) begin
          bus.us_cmd_fifo_rd_en_o = 1'b1;
          state_d                 = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_cpl)     state_d = ST_CPL_REQ;
        else if (dec_wr) state_d = ST_WR_REQ;
        else             state_d = ST_IDLE;
      end
      ST_CPL_REQ: begin
        bus.tx_req_o = 1'b1;
        if (bus.tx_ack_i) state_d = ST_IDLE;
      end
      ST_WR_REQ: begin
        bus.tx_req_o = 1'b1;
        if (bus.tx_ack_i) state_d = last_chunk ? ST_DONE : ST_WR_GAP;
      end
      ST_WR_GAP: state_d = ST_WR_REQ;
      ST_DONE: begin
        up_wr_cmd_compl_o = 1'b1;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      err_q    <= '0;
      pop_ok_q <= 1'b0;
    end else begin
      pop_ok_q <= 1'b1;
      if (state_q == ST_FETCH) cmd_q <= bus.us_cmd_fifo_dout_i;
      if (state_q == ST_DECODE) begin
        if (dec_wr) begin
          addr_q <= {cmd_q[31:2], 2'b00};
          rem_q  <= 17'd1 << len_clamp;
        end else if (dec_bad && (err_q != 8'hFF)) begin
          err_q <= err_q + 8'd1;
        end
      end
      if ((state_q == ST_WR_REQ) && bus.tx_ack_i) begin
        addr_q <= addr_q + {15'd0, chunk};
        rem_q  <= rem_q - chunk;
      end
    end
  end

  // A full 4096-byte chunk yields 0 on the 10-bit length, the usual 1024-DW encoding.
  assign bus.tx_type_o     = dec_type;
  assign bus.tx_addr_o     = addr_q;
  assign bus.tx_len_o      = (dec_type == CMD_WR32) ? chunk[11:2] : 10'd0;
  assign bus.tx_cpl_info_o = cmd_q[54:0];

  assign cmd_id_o    = cmd_q[56:55];
  assign busy_o      = (state_q != ST_IDLE);
  assign err_cnt_o   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_us_cmd_dispatch.sv
// Bench for us_cmd_dispatch: FIFO and TX-engine models, reference model feeding an
// expected-event queue, and a negedge monitor that checks every request and completion.
module tb_us_cmd_dispatch;
  localparam int MAXP = 128;
  localparam logic [1:0] K_CPL = 2'd0, K_WR = 2'd1, K_CMP = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [9:0]  len;
    logic [54:0] info;
    logic [1:0]  id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         compl;
  logic [1:0]   cmd_id;
  logic         busy;
  logic [7:0]   err_cnt;
  logic [2:0]   dbg_state;

  exp_t         exp_q[$];
  logic [127:0] fifo_q[$];
  logic [7:0]   exp_err = 8'd0;
  int           total = 0;
  int           bad = 0;
  int           req_seen = 0;
  int           ack_mode = 1;      // 0 random, 1 always, 2 never
  logic         ack_noise = 1'b0;
  logic         prev_rd = 1'b0;
  logic         do_pop;
  exp_t         mf;
  logic         mok;

  us_cmd_dispatch_if bus ();

  us_cmd_dispatch #(.MAX_PAYLOAD_BYTES(MAXP)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus.master),
    .up_wr_cmd_compl_o (compl),
    .cmd_id_o          (cmd_id),
    .busy_o            (busy),
    .err_cnt_o         (err_cnt),
    .dbg_state_o       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // reference model: expand one command into the TX events it must produce
  task automatic push_cmd(input logic [1:0] t, input logic [4:0] len, input logic [1:0] id,
                          input logic [54:0] info);
    logic [127:0] w;
    exp_t         e;
    int           lc, bytes, room, ch;
    logic [31:0]  a;
    w = {$urandom(), $urandom(), t, len, id, info};
    if (t == 2'd1 || t == 2'd2) begin
      e = '0; e.kind = K_CPL; e.typ = t; e.info = info; e.id = id;
      exp_q.push_back(e);
    end else if (t == 2'd3) begin
      lc = (len < 5'd2) ? 2 : ((len > 5'd16) ? 16 : int'(len));
      bytes = 1 << lc;
      a = {info[31:2], 2'b00};
      while (bytes > 0) begin
        room = 4096 - int'(a[11:0]);
        ch = bytes;
        if (MAXP < ch) ch = MAXP;
        if (room < ch) ch = room;
        e = '0; e.kind = K_WR; e.typ = t; e.addr = a; e.len = 10'(ch / 4); e.id = id;
        exp_q.push_back(e);
        a = a + 32'(ch);
        bytes -= ch;
      end
      e = '0; e.kind = K_CMP; e.id = id;
      exp_q.push_back(e);
    end else if (exp_err != 8'd255) begin
      exp_err++;
    end
    fifo_q.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || bus.us_cmd_fifo_empty_i !== 1'b1 ||
            busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: %0d cycles, fifo=%0d exp=%0d left, required drain", name, n,
               fifo_q.size(), exp_q.size());
    end
    repeat (2) @(negedge clk);
    chk({name, "_busy"}, 128'(busy), 128'(0));
    chk({name, "_err_cnt"}, 128'(err_cnt), 128'(exp_err));
  endtask

  // FIFO model: 1-cycle read latency after rd_en
  initial begin
    bus.us_cmd_fifo_empty_i = 1'b1;
    bus.us_cmd_fifo_dout_i  = '0;
    forever begin
      @(negedge clk);
      do_pop = bus.us_cmd_fifo_rd_en_o;
      @(posedge clk);
      #1;
      if (do_pop) begin
        total++;
        if (fifo_q.size() == 0) begin
          bad++;
          $display("FAIL fifo_underflow: rd_en with empty FIFO, required no pop");
        end else begin
          bus.us_cmd_fifo_dout_i = fifo_q.pop_front();
        end
      end
      bus.us_cmd_fifo_empty_i = (fifo_q.size() == 0);
    end
  end

  // monitor + TX engine: checks presented requests/completions, drives ack
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_ack_i = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (bus.us_cmd_fifo_rd_en_o) begin
        total++;
        if (prev_rd || busy) begin
          bad++;
          $display("FAIL rd_en_pulse: prev_rd=%0b busy=%0b, required 0/0", prev_rd, busy);
        end
      end
      prev_rd = bus.us_cmd_fifo_rd_en_o;
      if (bus.tx_req_o) begin
        req_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_req: type=%0d addr=%h len=%0d, required no request",
                   bus.tx_type_o, bus.tx_addr_o, bus.tx_len_o);
        end else begin
          mf = exp_q[0];
          if (mf.kind == K_CPL)
            mok = (bus.tx_type_o == mf.typ) && (bus.tx_len_o == 10'd0) && (bus.tx_cpl_info_o == mf.info);
          else if (mf.kind == K_WR)
            mok = (bus.tx_type_o == mf.typ) && (bus.tx_len_o == mf.len) && (bus.tx_addr_o == mf.addr);
          else
            mok = 1'b0;
          if (!mok) begin
            bad++;
            $display("FAIL tx_req: got type=%0d addr=%h len=%0d info=%h, required kind=%0d type=%0d addr=%h len=%0d info=%h",
                     bus.tx_type_o, bus.tx_addr_o, bus.tx_len_o, bus.tx_cpl_info_o,
                     mf.kind, mf.typ, mf.addr, mf.len, mf.info);
          end
        end
        if (ack_mode == 1 || (ack_mode == 0 && $urandom_range(0, 2) != 0)) begin
          bus.tx_ack_i = 1'b1;
          if (exp_q.size() > 0 && exp_q[0].kind != K_CMP) mf = exp_q.pop_front();
        end else begin
          bus.tx_ack_i = 1'b0;
        end
      end else begin
        bus.tx_ack_i = ack_noise && ($urandom_range(0, 3) == 0);
      end
      if (compl) begin
        total++;
        if (exp_q.size() == 0 || exp_q[0].kind != K_CMP || exp_q[0].id != cmd_id) begin
          bad++;
          $display("FAIL compl: cmd_id=%0d pending=%0d, required a completion for the head command",
                   cmd_id, exp_q.size());
        end
        if (exp_q.size() > 0 && exp_q[0].kind == K_CMP) mf = exp_q.pop_front();
      end
    end
  end

  // stimulus
  initial begin
    logic [1:0]  t;
    logic [4:0]  l;
    logic [31:0] a;
    int          n;
    int          seen0;
    rst_n = 1'b0;
    // queued before reset release: the pop must wait for reset to end
    push_cmd(2'd1, 5'd0, 2'd0, 55'h12345);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 128'(bus.us_cmd_fifo_rd_en_o), 128'(0));
    chk("rst_tx_req", 128'(bus.tx_req_o), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_compl", 128'(compl), 128'(0));
    chk("rst_err", 128'(err_cnt), 128'(0));
    chk("rst_outs", {bus.tx_type_o, bus.tx_addr_o, bus.tx_len_o, bus.tx_cpl_info_o, cmd_id}, 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("cpl", 50);

    push_cmd(2'd3, 5'd9, 2'd1, {23'h0, 32'h1000_0000});
    wait_drain("wr_len9", 100);
    push_cmd(2'd3, 5'd8, 2'd2, {23'h7_1234, 32'h0000_0FC0});
    wait_drain("wr_4k_split", 100);
    push_cmd(2'd3, 5'd0, 2'd3, {23'h0, 32'h0000_0020});
    wait_drain("wr_len0", 50);
    push_cmd(2'd3, 5'd20, 2'd0, {23'h0, 32'h0000_4000});
    wait_drain("wr_len20", 3000);
    push_cmd(2'd3, 5'd8, 2'd1, {23'h0, 32'hFFFF_FFC3});
    wait_drain("wr_wrap", 100);

    seen0 = req_seen;
    push_cmd(2'd0, 5'd3, 2'd0, 55'h0);
    push_cmd(2'd0, 5'd7, 2'd2, 55'h55);
    wait_drain("invalid2", 50);
    chk("invalid_no_req", 128'(req_seen - seen0), 128'(0));
    chk("invalid_err2", 128'(err_cnt), 128'(2));

    ack_mode = 0;
    ack_noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      t = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12));
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 64));
      push_cmd(t, l, 2'($urandom_range(0, 3)), {23'($urandom()), a});
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain("random", 20000);

    for (int i = 0; i < 260; i++) push_cmd(2'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 55'($urandom()));
    wait_drain("err_saturate", 3000);
    chk("err_sat_255", 128'(err_cnt), 128'(255));

    ack_mode = 2;
    ack_noise = 1'b0;
    push_cmd(2'd3, 5'd20, 2'd2, {23'h0, 32'h0000_8000});
    n = 0;
    while (bus.tx_req_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wr_req_seen", 128'(bus.tx_req_o), 128'(1));
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_req", 128'(bus.tx_req_o), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_compl", 128'(compl), 128'(0));
    chk("mid_rst_err", 128'(err_cnt), 128'(0));
    chk("mid_rst_rd_en", 128'(bus.us_cmd_fifo_rd_en_o), 128'(0));
    exp_q.delete();
    exp_err = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 0;

    push_cmd(2'd2, 5'd0, 2'd3, 55'h7F_0000_ABCD_1234);
    push_cmd(2'd3, 5'd10, 2'd2, {23'h0, 32'h0001_0F00});
    wait_drain("post_reset", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
